// File: rtl/seq_mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: opcodes,
// FSM state encoding and a two's-complement magnitude helper.
package seq_mdu_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Widest value the helper handles; callers zero-extend into it and
  // truncate the result back, which is exact for two's-complement negation.
  localparam int MAXW = 128;

  // Conditional two's-complement negation (magnitude of a negative value,
  // or sign restoration of a magnitude).
  function automatic logic [MAXW-1:0] twos_mag(input logic [MAXW-1:0] x,
                                               input logic            neg);
    return neg ? (~x + MAXW'(1)) : x;
  endfunction

endpackage

// File: rtl/seq_mdu_if.sv
// Request/response bundle between the execute stage and the MDU.
interface seq_mdu_if #(
  parameter int N = 32
);
  logic         start;
  logic [2:0]   opCode;
  logic [N-1:0] busA;
  logic [N-1:0] busB;
  logic         busy;
  logic         done;
  logic         divByZero;
  logic [N-1:0] hi;
  logic [N-1:0] lo;

  modport master (
    output start, opCode, busA, busB,
    input  busy, done, divByZero, hi, lo
  );

  modport slave (
    input  start, opCode, busA, busB,
    output busy, done, divByZero, hi, lo
  );
endinterface

// File: rtl/seq_mdu_step.sv
// One iteration of the MDU datapath: a shift-add multiply step or a
// restoring shift-subtract divide step on a 2N+1 bit accumulator.
// Multiply: acc = {partial product (N+1), multiplier bits still to consume (N)}.
// Divide:   acc = {partial remainder (N+1), dividend/quotient bits (N)}.
module mdu_step #(
  parameter int N = 32
) (
  input  logic [2*N:0] acc,
  input  logic [N-1:0] operand,
  input  logic         div_mode,
  output logic [2*N:0] acc_next
);

  logic [N:0]   sum;
  logic [2*N:0] shifted;
  logic [N+1:0] diff;

  // Compute both candidate steps and select by mode.
  always_comb begin
    sum      = '0;
    shifted  = '0;
    diff     = '0;
    acc_next = acc;
    if (div_mode) begin
      shifted = {acc[2*N-1:0], 1'b0};
      diff    = {1'b0, shifted[2*N:N]} - {2'b00, operand};
      if (!diff[N+1]) begin
        acc_next = {diff[N:0], shifted[N-1:1], 1'b1};
      end else begin
        acc_next = shifted;
      end
    end else begin
      sum      = acc[2*N:N] + (acc[0] ? {1'b0, operand} : {(N+1){1'b0}});
      acc_next = {1'b0, sum, acc[N-1:1]};
    end
  end

endmodule

// File: rtl/seq_mdu.sv
// Iterative multiply/divide unit with architectural HI/LO registers.
// Mult/div take N iteration cycles plus one sign-fix cycle, then a
// one-cycle done pulse; MTHI/MTLO and divide-by-zero finish immediately.
module seq_mdu
  import seq_mdu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic    clk,
  input  logic    reset,
  seq_mdu_if.slave bus
);

  localparam int CW = $clog2(N) + 1;

  state_t         state, next_state;
  logic [CW-1:0]  counter;
  logic [2*N:0]   acc;
  logic [2*N:0]   acc_next;
  logic [N-1:0]   opnd;
  logic           is_div;
  logic           neg_res;
  logic           neg_rem;
  logic           dbz;
  logic [N-1:0]   hi_r;
  logic [N-1:0]   lo_r;

  logic           signed_op;
  logic           div_op;
  logic           zero_div;
  logic           a_neg;
  logic           b_neg;
  logic [N-1:0]   mag_a;
  logic [N-1:0]   mag_b;
  logic [2*N-1:0] prod_fix;
  logic [N-1:0]   quo_fix;
  logic [N-1:0]   rem_fix;

  mdu_step #(.N(N)) u_step (
    .acc      (acc),
    .operand  (opnd),
    .div_mode (is_div),
    .acc_next (acc_next)
  );

  // Operand decode at acceptance and sign restoration for the FIX cycle.
  always_comb begin
    signed_op = (bus.opCode == OP_MULT) || (bus.opCode == OP_DIV);
    div_op    = (bus.opCode == OP_DIV) || (bus.opCode == OP_DIVU);
    zero_div  = div_op && (bus.busB == '0);
    a_neg     = signed_op && bus.busA[N-1];
    b_neg     = signed_op && bus.busB[N-1];
    mag_a     = N'(twos_mag(MAXW'(bus.busA), a_neg));
    mag_b     = N'(twos_mag(MAXW'(bus.busB), b_neg));
    prod_fix  = (2*N)'(twos_mag(MAXW'(acc[2*N-1:0]), neg_res));
    quo_fix   = N'(twos_mag(MAXW'(acc[N-1:0]), neg_res));
    rem_fix   = N'(twos_mag(MAXW'(acc[2*N-1:N]), neg_rem));
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; starts are only honoured in IDLE.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          case (bus.opCode)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU:
              next_state = zero_div ? DONE : RUN;
            OP_MTHI, OP_MTLO:
              next_state = DONE;
            default:
              next_state = IDLE;
          endcase
        end
      end
      RUN:     next_state = (counter == CW'(N-1)) ? FIX : RUN;
      FIX:     next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath: operand latch, iteration, and HI/LO writeback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      counter <= '0;
      acc     <= '0;
      opnd    <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      dbz     <= 1'b0;
      hi_r    <= '0;
      lo_r    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            case (bus.opCode)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                dbz <= zero_div;
                if (zero_div) begin
                  hi_r <= bus.busA;
                  lo_r <= '1;
                end else begin
                  acc     <= {{(N+1){1'b0}}, mag_a};
                  opnd    <= mag_b;
                  is_div  <= div_op;
                  neg_res <= a_neg ^ b_neg;
                  neg_rem <= a_neg;
                  counter <= '0;
                end
              end
              OP_MTHI: begin
                dbz  <= 1'b0;
                hi_r <= bus.busA;
              end
              OP_MTLO: begin
                dbz  <= 1'b0;
                lo_r <= bus.busA;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          acc     <= acc_next;
          counter <= counter + CW'(1);
        end
        FIX: begin
          if (is_div) begin
            hi_r <= rem_fix;
            lo_r <= quo_fix;
          end else begin
            hi_r <= prod_fix[2*N-1:N];
            lo_r <= prod_fix[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state == RUN) || (state == FIX);
  assign bus.done      = (state == DONE);
  assign bus.divByZero = dbz;
  assign bus.hi        = hi_r;
  assign bus.lo        = lo_r;

endmodule
